// File: rtl/sram_port_master.sv
// sram_port_master
// Burst initiator for a single-port 1rw SRAM macro (clk0/csb0/web0/addr0/din0/dout0).
// Accepts read/write burst commands from a host, walks the address with wrap-around,
// and returns read data two cycles after each beat is issued to the macro.
//
// Ports:
//   clk0, rst0_n            clock, asynchronous active-low reset
//   cmd_valid/ready/we/addr/len  burst command handshake (accepted in IDLE only)
//   wdata_valid/ready/wdata write beat handshake (ready in WRITE only)
//   rdata_valid/rdata/rdata_last  read beat return, no backpressure
//   busy                    high whenever not IDLE
//   csb0/web0/addr0/din0    registered macro controls (active-low csb0/web0)
//   dout0                   macro read data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// WRITE | one macro write per cycle that wdata_valid is high
// READ  | one macro read per cycle, unconditionally
// DRAIN | all reads issued; wait for the last beat to return
module sram_port_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_STEP  = LEN_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]    beats_left_q, beats_left_d;
    logic                    csb0_q, csb0_d;
    logic                    web0_q, web0_d;
    logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0]   din0_q, din0_d;
    logic                    issue_rd, issue_last;

    // Read return pipeline: [0] = beat on macro port, [1] = macro has sampled it.
    logic [1:0]              rd_vld_q, rd_last_q;
    logic                    rdata_valid_q, rdata_last_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        csb0_d       = 1'b1;
        web0_d       = 1'b1;
        addr0_d      = addr0_q;
        din0_d       = din0_q;
        issue_rd     = 1'b0;
        issue_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d   = cmd_addr;
                    beats_left_d = cmd_len;
                    state_d      = cmd_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    csb0_d       = 1'b0;
                    web0_d       = 1'b0;
                    addr0_d      = cur_addr_q;
                    din0_d       = wdata;
                    cur_addr_d   = cur_addr_q + ADDR_STEP;
                    beats_left_d = beats_left_q - LEN_STEP;
                    if (beats_left_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                csb0_d       = 1'b0;
                addr0_d      = cur_addr_q;
                issue_rd     = 1'b1;
                cur_addr_d   = cur_addr_q + ADDR_STEP;
                beats_left_d = beats_left_q - LEN_STEP;
                if (beats_left_q == '0) begin
                    issue_last = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave one edge after the final beat is presented to the host.
                if (rdata_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            csb0_q       <= 1'b1;
            web0_q       <= 1'b1;
            addr0_q      <= '0;
            din0_q       <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            csb0_q       <= csb0_d;
            web0_q       <= web0_d;
            addr0_q      <= addr0_d;
            din0_q       <= din0_d;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            rd_vld_q      <= '0;
            rd_last_q     <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rd_vld_q      <= {rd_vld_q[0], issue_rd};
            rd_last_q     <= {rd_last_q[0], issue_last};
            rdata_valid_q <= rd_vld_q[1];
            rdata_last_q  <= rd_vld_q[1] & rd_last_q[1];
            if (rd_vld_q[1]) begin
                rdata_q <= dout0;
            end
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign csb0        = csb0_q;
    assign web0        = web0_q;
    assign addr0       = addr0_q;
    assign din0        = din0_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_sram_port_master.sv
// Testbench for sram_port_master: behavioural SRAM macro on the port side,
// expected-memory model and per-cycle timing expectations on the host side.
module tb_sram_port_master;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int LW = 4;

    logic          clk0 = 1'b0;
    logic          rst0_n = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_last, busy;
    logic [DW-1:0] rdata;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0, dout0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] wbuf    [16];
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] sram    [128];
    logic [DW-1:0] dout_q = '0;

    logic          hold_cmd = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [LW-1:0] hold_len = '0;

    sram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .busy(busy),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    always #5 clk0 = ~clk0;

    // Macro behaviour: samples controls on the rising edge, read data valid after it.
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) sram[addr0] <= din0;
            else       dout_q <= sram[addr0];
        end
    end
    assign dout0 = dout_q;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int off);
        return AW'((int'(base) + off) % 128);
    endfunction

    // Write n beats from wbuf starting at addr; optionally withhold wdata_valid
    // for stall_len cycles just before beat stall_at.
    task automatic write_burst(input logic [AW-1:0] addr, input int n,
                               input int stall_at, input int stall_len);
        chk("wr_cmd_ready_idle", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_we      = 1'b1;
        cmd_addr    = addr;
        cmd_len     = LW'(n - 1);
        wdata_valid = 1'b0;
        tick();
        if (hold_cmd) begin
            cmd_valid = 1'b1;
            cmd_we    = 1'b0;
            cmd_addr  = hold_addr;
            cmd_len   = hold_len;
        end else begin
            cmd_valid = 1'b0;
        end
        chk("wr_busy_accept", busy, 1);
        chk("wr_wdata_ready", wdata_ready, 1);
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    wdata_valid = 1'b0;
                    tick();
                    chk("wr_stall_csb0", csb0, 1);
                    chk("wr_stall_web0", web0, 1);
                    chk("wr_stall_cmd_ready", cmd_ready, 0);
                    if (b > 0) chk("wr_stall_addr_hold", addr0, wrap(addr, b - 1));
                end
            end
            wdata_valid = 1'b1;
            wdata       = wbuf[b];
            tick();
            ref_mem[wrap(addr, b)] = wbuf[b];
            chk("wr_csb0", csb0, 0);
            chk("wr_web0", web0, 0);
            chk("wr_addr0", addr0, wrap(addr, b));
            chk("wr_din0", din0, wbuf[b]);
            chk("wr_busy", busy, (b == n - 1) ? 0 : 1);
            chk("wr_cmd_ready", cmd_ready, (b == n - 1) ? 1 : 0);
        end
        wdata_valid = 1'b0;
    endtask

    // Read n beats from addr and check macro issue, return data and timing:
    // accepted at edge T, beat i issued at T+1+i, returned at T+3+i, IDLE at T+n+3.
    task automatic read_burst(input logic [AW-1:0] addr, input int n);
        chk("rd_cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = addr;
        cmd_len   = LW'(n - 1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= n + 3; k++) begin
            tick();
            if (k <= n) begin
                chk("rd_csb0", csb0, 0);
                chk("rd_web0", web0, 1);
                chk("rd_addr0", addr0, wrap(addr, k - 1));
            end else begin
                chk("rd_csb0_idle", csb0, 1);
            end
            if (k >= 3 && k <= n + 2) begin
                chk("rd_valid", rdata_valid, 1);
                chk("rd_data", rdata, ref_mem[wrap(addr, k - 3)]);
                chk("rd_last", rdata_last, (k == n + 2) ? 1 : 0);
            end else begin
                chk("rd_valid_quiet", rdata_valid, 0);
                chk("rd_last_quiet", rdata_last, 0);
            end
            chk("rd_busy", busy, (k < n + 3) ? 1 : 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_csb0"}, csb0, 1);
        chk({tag, "_web0"}, web0, 1);
        chk({tag, "_addr0"}, addr0, 0);
        chk({tag, "_din0"}, din0, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rdata_valid"}, rdata_valid, 0);
        chk({tag, "_rdata_last"}, rdata_last, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_wdata_ready"}, wdata_ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;

        // Asynchronous reset before any clock edge.
        #2 rst0_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        repeat (2) @(posedge clk0);
        #3 rst0_n = 1'b1;

        // Fill the whole memory so every later read has a known value.
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 16; j++) wbuf[j] = $urandom;
            write_burst(AW'(b * 16), 16, -1, 0);
        end

        // Write then read, 4 beats at 10.
        wbuf[0] = 32'hFACECAFE; wbuf[1] = 32'hFACECAFF;
        wbuf[2] = 32'hFACECB00; wbuf[3] = 32'hFACECB01;
        write_burst(7'd10, 4, -1, 0);
        read_burst(7'd10, 4);

        // Address wrap 126,127,0.
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
        write_burst(7'd126, 3, -1, 0);
        read_burst(7'd126, 3);

        // Two-cycle stall after the first beat.
        for (int j = 0; j < 4; j++) wbuf[j] = $urandom;
        write_burst(7'd40, 4, 1, 2);
        read_burst(7'd40, 4);

        // Read command held during a write burst; taken once back in IDLE.
        for (int j = 0; j < 4; j++) wbuf[j] = $urandom;
        hold_cmd = 1'b1; hold_addr = 7'd10; hold_len = 4'd3;
        write_burst(7'd60, 4, -1, 0);
        hold_cmd = 1'b0;
        read_burst(7'd10, 4);
        read_burst(7'd60, 4);

        // Reset after the 2nd of 8 read beats is issued.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 7'd10; cmd_len = 4'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_rd_csb0_before", csb0, 0);
        #2 rst0_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        tick();
        tick();
        #3 rst0_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_rdata_valid", rdata_valid, 0);
            chk("post_rst_csb0", csb0, 1);
            chk("post_rst_busy", busy, 0);
        end
        read_burst(7'd10, 8);

        // Randomised mix of bursts.
        for (int it = 0; it < 20; it++) begin
            logic [AW-1:0] a;
            int n;
            int sa;
            a = AW'($urandom_range(0, 127));
            n = int'($urandom_range(1, 16));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 16; j++) wbuf[j] = $urandom;
                sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
                write_burst(a, n, sa, int'($urandom_range(1, 3)));
            end else begin
                read_burst(a, n);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
